// File: rtl/laser_wave_scheduler.sv
// Laser hazard sequencer: randomised beam waves walked through
// gap -> warn -> fire, with a single hit strobe per wave.
module laser_wave_scheduler #(
  parameter int unsigned GAP_TICKS  = 1500000,
  parameter int unsigned WARN_TICKS = 2500000,
  parameter int unsigned FIRE_TICKS = 3750000,
  parameter int unsigned ARM_TICKS  = 2182500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_game,
  input  logic [11:0] mic_in,
  input  logic [6:0]  x_player,
  input  logic [6:0]  y_player,
  output logic [1:0]  phase,
  output logic [2:0]  v_mask,
  output logic [2:0]  h_mask,
  output logic [6:0]  v_x0,
  output logic [6:0]  v_x1,
  output logic [6:0]  v_x2,
  output logic [6:0]  h_y0,
  output logic [6:0]  h_y1,
  output logic [6:0]  h_y2,
  output logic        hit_pulse,
  output logic [7:0]  wave_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    WARN = 2'd2,
    FIRE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [2:0][6:0] vx_q, vx_d;
  logic [2:0][6:0] hy_q, hy_d;
  logic [2:0]      vm_q, vm_d;
  logic [2:0]      hm_q, hm_d;
  logic            hit_q, hit_d;
  logic [7:0]      wc_q, wc_d;

  logic [15:0]     e;
  logic [2:0]      n;
  logic [7:0]      x8, y8;
  logic            overlap;
  logic            armed;

  function automatic logic [6:0] pos_v(
    input logic [6:0] r
  );
    return ((r >= 7'd72) ? r - 7'd72 : r) + 7'd20;
  endfunction

  function automatic logic [6:0] pos_h(
    input logic [5:0] r
  );
    logic [6:0] w;
    w = {1'b0, r};
    return ((w >= 7'd38) ? w - 7'd38 : w) + 7'd16;
  endfunction

  always_comb begin
    e      = lfsr_q ^ {mic_in, 4'b0000};
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
              lfsr_q[15:1]};
    n      = {1'b0, e[1:0]} + 3'd3;
    x8     = {1'b0, x_player};
    y8     = {1'b0, y_player};
    armed  = (cnt_q >= 32'(ARM_TICKS));

    // 8-bit compares so the +2 beam width never wraps
    overlap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (vm_q[i] && x8 >= {1'b0, vx_q[i]} &&
          x8 <= {1'b0, vx_q[i]} + 8'd2)
        overlap = 1'b1;
      if (hm_q[i] && y8 >= {1'b0, hy_q[i]} &&
          y8 <= {1'b0, hy_q[i]} + 8'd2)
        overlap = 1'b1;
    end

    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    vx_d    = vx_q;
    hy_d    = hy_q;
    vm_d    = vm_q;
    hm_d    = hm_q;
    hit_d   = 1'b0;
    wc_d    = wc_q;

    if (!start_game) begin
      state_d = IDLE;
      cnt_d   = '0;
      vx_d    = '0;
      hy_d    = '0;
      vm_d    = '0;
      hm_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = GAP;
          cnt_d   = '0;
        end
        GAP: begin
          if (cnt_q == 32'(GAP_TICKS - 1)) begin
            state_d  = WARN;
            cnt_d    = '0;
            vx_d[0]  = pos_v(e[6:0]);
            vx_d[1]  = pos_v(e[13:7]);
            vx_d[2]  = pos_v({e[15:14], e[4:0]});
            hy_d[0]  = pos_h(e[5:0]);
            hy_d[1]  = pos_h(e[11:6]);
            hy_d[2]  = pos_h({e[15:12], e[1:0]});
            vm_d     = {n >= 3'd5, 1'b1, 1'b1};
            hm_d     = {n == 3'd6, n >= 3'd4, 1'b1};
            if (wc_q != 8'hFF)
              wc_d = wc_q + 8'd1;
          end
        end
        WARN: begin
          if (cnt_q == 32'(WARN_TICKS - 1)) begin
            state_d = FIRE;
            cnt_d   = '0;
          end
        end
        FIRE: begin
          if ((armed && overlap) ||
              cnt_q == 32'(FIRE_TICKS - 1)) begin
            hit_d   = armed && overlap;
            state_d = GAP;
            cnt_d   = '0;
            vx_d    = '0;
            hy_d    = '0;
            vm_d    = '0;
            hm_d    = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= 16'hACE1;
      vx_q    <= '0;
      hy_q    <= '0;
      vm_q    <= '0;
      hm_q    <= '0;
      hit_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      vx_q    <= vx_d;
      hy_q    <= hy_d;
      vm_q    <= vm_d;
      hm_q    <= hm_d;
      hit_q   <= hit_d;
      wc_q    <= wc_d;
    end
  end

  assign phase      = state_q;
  assign v_mask     = vm_q;
  assign h_mask     = hm_q;
  assign v_x0       = vx_q[0];
  assign v_x1       = vx_q[1];
  assign v_x2       = vx_q[2];
  assign h_y0       = hy_q[0];
  assign h_y1       = hy_q[1];
  assign h_y2       = hy_q[2];
  assign hit_pulse  = hit_q;
  assign wave_count = wc_q;

endmodule

// File: tb/tb_laser_wave_scheduler.sv
// Bench for laser_wave_scheduler: random stimulus against a
// tick-level behavioural model plus directed scenario checks.
module tb_laser_wave_scheduler;

  localparam int GAP  = 4;
  localparam int WARN = 3;
  localparam int FIRE = 6;
  localparam int ARM  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_game;
  logic [11:0] mic_in;
  logic [6:0]  x_player, y_player;
  logic [1:0]  phase;
  logic [2:0]  v_mask, h_mask;
  logic [6:0]  v_x0, v_x1, v_x2;
  logic [6:0]  h_y0, h_y1, h_y2;
  logic        hit_pulse;
  logic [7:0]  wave_count;

  int n_checks = 0;
  int n_errors = 0;
  bit mic_rand;

  // model state: phase, cycles spent in phase, wave fields
  int       m_ph, m_t, m_wc;
  int       m_vx[3], m_hy[3];
  bit [2:0] m_vm, m_hm;
  bit       m_hit;
  bit [15:0] m_lfsr;

  laser_wave_scheduler #(
    .GAP_TICKS (GAP),
    .WARN_TICKS(WARN),
    .FIRE_TICKS(FIRE),
    .ARM_TICKS (ARM)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .start_game(start_game),
    .mic_in    (mic_in),
    .x_player  (x_player),
    .y_player  (y_player),
    .phase     (phase),
    .v_mask    (v_mask),
    .h_mask    (h_mask),
    .v_x0      (v_x0),
    .v_x1      (v_x1),
    .v_x2      (v_x2),
    .h_y0      (h_y0),
    .h_y1      (h_y1),
    .h_y2      (h_y2),
    .hit_pulse (hit_pulse),
    .wave_count(wave_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int dur(input int ph);
    case (ph)
      1: return GAP;
      2: return WARN;
      default: return FIRE;
    endcase
  endfunction

  function automatic bit [15:0] lfsr_adv(input bit [15:0] s);
    bit b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | (16'(b) << 15);
  endfunction

  function automatic bit on_beam();
    int x, y;
    x = int'(x_player);
    y = int'(y_player);
    on_beam = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_vm[i] && x >= m_vx[i] && x <= m_vx[i] + 2)
        on_beam = 1'b1;
      if (m_hm[i] && y >= m_hy[i] && y <= m_hy[i] + 2)
        on_beam = 1'b1;
    end
  endfunction

  task automatic clear_fields();
    for (int i = 0; i < 3; i++) begin
      m_vx[i] = 0;
      m_hy[i] = 0;
    end
    m_vm = 0;
    m_hm = 0;
  endtask

  task automatic latch_fields(input bit [15:0] e);
    int n;
    n = int'(e[1:0]) + 3;
    m_vx[0] = int'(e[6:0]) % 72 + 20;
    m_vx[1] = int'(e[13:7]) % 72 + 20;
    m_vx[2] = int'({e[15:14], e[4:0]}) % 72 + 20;
    m_hy[0] = int'(e[5:0]) % 38 + 16;
    m_hy[1] = int'(e[11:6]) % 38 + 16;
    m_hy[2] = int'({e[15:12], e[1:0]}) % 38 + 16;
    m_vm = {n >= 5, 1'b1, 1'b1};
    m_hm = {n == 6, n >= 4, 1'b1};
  endtask

  task automatic model_step();
    bit [15:0] e;
    e = m_lfsr ^ {mic_in, 4'h0};
    m_lfsr = lfsr_adv(m_lfsr);
    m_hit = 1'b0;
    if (reset) begin
      m_lfsr = 16'hACE1;
      m_ph = 0;
      m_t = 0;
      m_wc = 0;
      clear_fields();
    end else if (!start_game) begin
      m_ph = 0;
      m_t = 0;
      clear_fields();
    end else if (m_ph == 0) begin
      m_ph = 1;
      m_t = 0;
    end else if (m_ph == 3 && m_t >= ARM && on_beam()) begin
      m_hit = 1'b1;
      m_ph = 1;
      m_t = 0;
      clear_fields();
    end else begin
      m_t++;
      if (m_t == dur(m_ph)) begin
        m_t = 0;
        if (m_ph == 1) begin
          latch_fields(e);
          m_wc = (m_wc < 255) ? m_wc + 1 : 255;
          m_ph = 2;
        end else if (m_ph == 2) begin
          m_ph = 3;
        end else begin
          m_ph = 1;
          clear_fields();
        end
      end
    end
  endtask

  task automatic compare_all();
    check("phase", phase, m_ph);
    check("v_mask", v_mask, m_vm);
    check("h_mask", h_mask, m_hm);
    check("hit", hit_pulse, m_hit);
    check("wave_count", wave_count, m_wc);
    check("v_x", {v_x0, v_x1, v_x2},
          64'(m_vx[0] * 16384 + m_vx[1] * 128 + m_vx[2]));
    check("h_y", {h_y0, h_y1, h_y2},
          64'(m_hy[0] * 16384 + m_hy[1] * 128 + m_hy[2]));
  endtask

  task automatic tick();
    if (mic_rand)
      mic_in = 12'($urandom);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_model(input int ph, input int t,
                            input int max);
    int k;
    k = 0;
    while (!(m_ph == ph && m_t == t)) begin
      if (k >= max) begin
        check("wait_timeout", 0, 1);
        return;
      end
      tick();
      k++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int  exp_ph[14] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 1};
  int  hits, wc_before, waves, cyc;
  bit  done_a, done_b, mode_a, mode_b;
  int  cand;

  initial begin
    reset = 1'b1;
    start_game = 1'b0;
    mic_in = '0;
    x_player = '0;
    y_player = '0;
    mic_rand = 1'b1;

    // reset and start
    tick();
    reset = 1'b0;
    check("rst_phase", phase, 2'd0);
    check("rst_masks", {v_mask, h_mask}, 6'd0);
    check("rst_wc", wave_count, 8'd0);
    check("rst_hit", hit_pulse, 1'b0);
    start_game = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("seq_phase", phase, exp_ph[i]);
      if (i == 4)
        check("seq_wc", wave_count, 8'd1);
    end

    // field decode with zero entropy
    wait_model(1, GAP - 1, 20);
    mic_rand = 1'b0;
    mic_in = '0;
    force dut.lfsr_q = 16'h0000;
    m_lfsr = 16'h0000;
    tick();
    release dut.lfsr_q;
    check("dec_phase", phase, 2'd2);
    check("dec_vx", {v_x0, v_x1, v_x2}, {7'd20, 7'd20, 7'd20});
    check("dec_hy", {h_y0, h_y1, h_y2}, {7'd16, 7'd16, 7'd16});
    check("dec_vmask", v_mask, 3'b011);
    check("dec_hmask", h_mask, 3'b001);
    mic_rand = 1'b1;
    do_reset();

    // lethal hit at the first armed FIRE cycle
    wait_model(2, 0, 20);
    x_player = 7'(m_vx[0] + 2);
    wait_model(3, 0, 20);
    hits = 0;
    for (int i = 0; i < ARM + 1; i++) begin
      check("arm_nohit", hit_pulse, 1'b0);
      check("arm_phase", phase, 2'd3);
      tick();
    end
    check("hit_pulse", hit_pulse, 1'b1);
    check("hit_phase", phase, 2'd1);
    check("hit_masks", {v_mask, h_mask}, 6'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      hits += int'(hit_pulse);
    end
    check("hit_once", hits, 0);
    x_player = '0;

    // misses: just right of beam 0, and on a disabled beam
    done_a = 0;
    done_b = 0;
    for (int w = 0; w < 60 && !(done_a && done_b); w++) begin
      wait_model(2, 0, 30);
      mode_a = 0;
      mode_b = 0;
      x_player = '0;
      y_player = '0;
      if (!done_a) begin
        x_player = 7'(m_vx[0] + 3);
        mode_a = !on_beam();
      end
      if (!mode_a && !done_b && m_vm[2] == 1'b0) begin
        x_player = 7'(m_vx[2]);
        mode_b = !on_beam();
      end
      if (!mode_a && !mode_b)
        x_player = '0;
      hits = 0;
      wait_model(3, 0, 20);
      for (int i = 0; i < FIRE; i++) begin
        tick();
        hits += int'(hit_pulse);
      end
      if (mode_a) begin
        check("miss_right", hits, 0);
        done_a = 1;
      end
      if (mode_b) begin
        check("miss_disabled", hits, 0);
        done_b = 1;
      end
    end
    check("miss_right_seen", done_a, 1'b1);
    check("miss_disabled_seen", done_b, 1'b1);
    x_player = '0;

    // stop mid-FIRE while overlapping
    wait_model(3, 3, 40);
    wc_before = m_wc;
    x_player = 7'(m_vx[0]);
    start_game = 1'b0;
    tick();
    check("stop_phase", phase, 2'd0);
    check("stop_hit", hit_pulse, 1'b0);
    check("stop_masks", {v_mask, h_mask}, 6'd0);
    check("stop_wc", wave_count, wc_before);
    x_player = '0;
    start_game = 1'b1;
    tick();
    check("restart_phase", phase, 2'd1);

    // reset mid-WARN
    wait_model(2, 1, 40);
    do_reset();
    check("midrst_phase", phase, 2'd0);
    check("midrst_wc", wave_count, 8'd0);
    check("midrst_hit", hit_pulse, 1'b0);

    // saturation under random play
    waves = 0;
    cyc = 0;
    while (waves < 260 && cyc < 20000) begin
      x_player = 7'($urandom_range(0, 127));
      y_player = 7'($urandom_range(0, 127));
      start_game = ($urandom_range(0, 63) != 0);
      tick();
      cyc++;
      if (m_ph == 2 && m_t == 0)
        waves++;
    end
    check("sat_waves", waves >= 260, 1'b1);
    check("sat_wc", wave_count, 8'd255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/laser_wave_scheduler.md
# laser_wave_scheduler

Sequences the laser hazards of the laser dodging mini-game. It generates randomised laser waves and walks each wave through a gap → warn → fire cycle. It reports a single hit event per wave when the player overlaps a live beam. It sits between the microphone sample source and the pixel renderer / life counter: the renderer consumes positions, masks and phase, and the life logic consumes `hit_pulse`.

## Interface
- `GAP_TICKS`, default 1500000, cycles with no lasers before each wave (≥1)
- `WARN_TICKS`, default 2500000, cycles lasers are shown harmless/white (≥1)
- `FIRE_TICKS`, default 3750000, cycles lasers are shown red (≥1)
- `ARM_TICKS`, default 2182500, grace cycles at start of FIRE before beams are lethal (< FIRE_TICKS)
- `clock` in 1, system clock
- `reset` in 1, synchronous, active-high
- `start_game` in 1, level; 1 = game running, 0 = hold idle
- `mic_in` in 12, raw mic sample, entropy source
- `x_player`, `y_player` in 7 each, player centre pixel
- `phase` out 2, 0 IDLE, 1 GAP, 2 WARN, 3 FIRE
- `v_mask` out 3, enabled vertical beams
- `h_mask` out 3, enabled horizontal beams
- `v_x0`, `v_x1`, `v_x2` out 7 each, left column of vertical beam i (beam is 3 px wide: x..x+2)
- `h_y0`, `h_y1`, `h_y2` out 7 each, top row of horizontal beam j (y..y+2)
- `hit_pulse` out 1, one-cycle hit strobe
- `wave_count` out 8, waves started, saturating

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Seeded to 16'hACE1 on `reset` only.
  - Advances every cycle, including while idle.
- **Entropy word:** e = lfsr ^ {mic_in, 4'b0000}.
- **Wave fields**, latched on the GAP→WARN edge:
  - v_x0 = e[6:0]%72+20
  - v_x1 = e[13:7]%72+20
  - v_x2 = {e[15:14],e[4:0]}%72+20, range 20..91
  - h_y0 = e[5:0]%38+16
  - h_y1 = e[11:6]%38+16
  - h_y2 = {e[15:12],e[1:0]}%38+16, range 16..53
  - Beams therefore never reach border columns 94/95 or rows 0/63.
- **Beam count:** n = e[1:0]+3 (3..6).
  - v_mask = {n≥5, 1, 1}
  - h_mask = {n==6, n≥4, 1}
- **FSM states:** IDLE, GAP, WARN, FIRE. One cycle counter `cnt` (32-bit) clears on every state change.
  - IDLE: when `start_game`=1, go to GAP.
  - GAP: when cnt==GAP_TICKS-1, go to WARN. Latch fields, increment wave_count (saturate at 255).
  - WARN: when cnt==WARN_TICKS-1, go to FIRE.
  - FIRE: when cnt==FIRE_TICKS-1, go to GAP.
  - FIRE with a hit, any cycle: go to GAP.
- **Hit condition:** phase==FIRE and cnt≥ARM_TICKS and the player overlaps a beam:
  - for any enabled i: v_xi ≤ x_player ≤ v_xi+2, or
  - for any enabled j: h_yj ≤ y_player ≤ h_yj+2.
  - Comparisons are unsigned 8-bit, so +2 cannot wrap.
- **Hit response:** `hit_pulse` asserts for exactly 1 cycle and the wave aborts. At most one hit per wave.
- **Stop:** `start_game`=0 in any state forces IDLE next cycle.
  - Clears phase, masks, positions, hit_pulse, cnt.
  - Does NOT clear wave_count or the LFSR.
- **Masks and positions:** valid only in WARN/FIRE. Forced to 0 in IDLE and GAP.

## Timing
- **Reset values:** phase=0, v_mask=h_mask=0, all positions 0, hit_pulse=0, wave_count=0, cnt=0.
- **Priority:** reset > start_game=0 > hit > phase timeout.
- All outputs are registered.
- **Phase durations:** GAP lasts exactly GAP_TICKS cycles, WARN exactly WARN_TICKS, uninterrupted FIRE exactly FIRE_TICKS.
- **Start latency:** IDLE→GAP 1 cycle after `start_game` is sampled high.
- **Field sampling:**
  - Positions and masks are valid from the first WARN cycle.
  - They are computed from `mic_in` and the LFSR sampled on the GAP→WARN clock edge.
- **Hit timing:**
  - The hit is evaluated on `x_player`/`y_player` as sampled in a FIRE cycle.
  - On the next cycle, hit_pulse=1 and phase=GAP with masks 0.
  - Earliest hit: FIRE cycle with cnt==ARM_TICKS.
- **Hit on the last FIRE cycle:** hit_pulse still asserts and the next phase is GAP.
- **wave_count** updates on the same edge that enters WARN.
- **Mid-wave reset or stop:** outputs reach their reset/idle values on the next cycle with no hit_pulse. A hit qualifying in that same cycle is dropped.

## Test plan
Parameters for all scenarios: GAP=4, WARN=3, FIRE=6, ARM=2.

1. **Reset and start:** reset 1 cycle, start_game=1 → phase 0→1 next cycle, GAP for 4 cycles, then WARN with wave_count=1, FIRE for 6 cycles, then GAP again.
2. **Field decode:** force LFSR=16'h0000 (reset seed override via hierarchical force), mic_in=12'h000 on the GAP→WARN edge → all v_x=20, all h_y=16, n=3, v_mask=3'b011, h_mask=3'b001.
3. **Lethal hit:** x_player=v_x0+2 during FIRE.
   - Response: no hit_pulse at cnt 0–1.
   - hit_pulse=1 for one cycle after the cnt==2 FIRE cycle.
   - phase=GAP on the same cycle, masks 0.
   - Only 1 hit counted per wave.
4. **Misses:** player on v_x0+3 and on a disabled beam's position → no hit_pulse through the full FIRE phase.
5. **Stop mid-FIRE:** start_game→0 at FIRE cnt 3 while overlapping → next cycle phase=0, no hit_pulse, wave_count held. Restart resumes from GAP.
6. **Saturation:** run 260 waves → wave_count stays 255.
